// File: rtl/tpu_pkg.sv
// rtl/tpu_pkg.sv - shared opcodes, FSM state type and TPU address helpers
package tpu_pkg;

    localparam logic [3:0] OP_A  = 4'h1;
    localparam logic [3:0] OP_B  = 4'h2;
    localparam logic [3:0] OP_C  = 4'h3;
    localparam logic [3:0] OP_MM = 4'h4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_A,
        ST_LOAD_B,
        ST_LOAD_C,
        ST_MATMUL,
        ST_WAIT,
        ST_READ_C,
        ST_DONE
    } state_e;

    function automatic logic [11:0] addr_op(input logic [3:0] op);
        return {op, 8'h00};
    endfunction

    function automatic logic [11:0] addr_a(input logic [4:0] row);
        return {OP_A, row, 3'b000};
    endfunction

    // C index packs {row, half}, so row<<4 | half<<3 collapses to idx<<3.
    function automatic logic [11:0] addr_c(input logic [4:0] idx);
        return {OP_C, idx, 3'b000};
    endfunction

endpackage

// File: rtl/tpu_out_skid.sv
// rtl/tpu_out_skid.sv - single-entry valid/ready output register
module tpu_out_skid #(
    parameter int W = 64
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         s_tvalid_i,
    input  logic [W-1:0] s_tdata_i,
    output logic         s_tready_o,
    output logic         m_tvalid_o,
    output logic [W-1:0] m_tdata_o,
    input  logic         m_tready_i
);

    logic         valid_q, valid_d;
    logic [W-1:0] data_q, data_d;

    assign s_tready_o = !valid_q || m_tready_i;
    assign m_tvalid_o = valid_q;
    assign m_tdata_o  = data_q;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (s_tvalid_i && s_tready_o) begin
            valid_d = 1'b1;
            data_d  = s_tdata_i;
        end else if (m_tready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/tpu_host_sequencer.sv
// rtl/tpu_host_sequencer.sv - tpuv1 slave-port master running one matmul job per start pulse
module tpu_host_sequencer #(
    parameter int DIM     = 8,
    parameter int BITS_C  = 16,
    parameter int ADDRW   = 16,
    parameter int DATAW   = 64,
    parameter int MM_WAIT = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             clear_c,
    output logic             busy,
    output logic             done,
    input  logic             in_valid,
    input  logic [DATAW-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [DATAW-1:0] out_data,
    input  logic             out_ready,
    output logic [ADDRW-1:0] tpu_addr,
    output logic             tpu_r_w,
    output logic [DATAW-1:0] tpu_dataIn,
    input  logic [DATAW-1:0] tpu_dataOut
);
    import tpu_pkg::*;

    localparam int C_WORDS = (DIM * BITS_C) / DATAW;
    localparam int N_C     = DIM * C_WORDS;
    localparam int IW      = $clog2(N_C);
    localparam int WW      = $clog2(MM_WAIT + 1);
    localparam logic [IW-1:0] IDX_A_LAST = IW'(DIM - 1);
    localparam logic [IW-1:0] IDX_C_LAST = IW'(N_C - 1);
    localparam logic [WW-1:0] WAIT_LAST  = WW'(MM_WAIT - 1);

    state_e           state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d, idx_nx;
    logic [WW-1:0]    wcnt_q, wcnt_d;
    logic             clr_q, clr_d;
    logic             last_q, last_d;
    logic [ADDRW-1:0] addr_q, addr_d;
    logic             rw_q, rw_d;
    logic [DATAW-1:0] din_q, din_d;
    logic             push_valid, push_ready;

    function automatic logic [ADDRW-1:0] ext(input logic [11:0] a);
        return {{(ADDRW - 12){1'b0}}, a};
    endfunction

    assign idx_nx     = idx_q + 1'b1;
    assign busy       = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign done       = (state_q == ST_DONE);
    assign tpu_addr   = addr_q;
    assign tpu_r_w    = rw_q;
    assign tpu_dataIn = din_q;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        wcnt_d     = wcnt_q;
        clr_d      = clr_q;
        last_d     = last_q;
        addr_d     = '0;
        rw_d       = 1'b0;
        din_d      = '0;
        in_ready   = 1'b0;
        push_valid = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LOAD_A;
                    clr_d   = clear_c;
                    idx_d   = '0;
                    wcnt_d  = '0;
                    last_d  = 1'b0;
                end
            end
            ST_LOAD_A, ST_LOAD_B: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    addr_d = (state_q == ST_LOAD_A) ? ext(addr_a(5'(idx_q))) : ext(addr_op(OP_B));
                    rw_d   = 1'b1;
                    din_d  = in_data;
                    if (idx_q == IDX_A_LAST) begin
                        idx_d   = '0;
                        state_d = (state_q == ST_LOAD_A) ? ST_LOAD_B : ST_LOAD_C;
                    end else begin
                        idx_d = idx_nx;
                    end
                end
            end
            ST_LOAD_C: begin
                in_ready = !clr_q;
                if (clr_q || in_valid) begin
                    addr_d = ext(addr_c(5'(idx_q)));
                    rw_d   = 1'b1;
                    din_d  = clr_q ? '0 : in_data;
                    if (idx_q == IDX_C_LAST) begin
                        idx_d   = '0;
                        state_d = ST_MATMUL;
                    end else begin
                        idx_d = idx_nx;
                    end
                end
            end
            ST_MATMUL: begin
                addr_d  = ext(addr_op(OP_MM));
                rw_d    = 1'b1;
                wcnt_d  = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // Present the first C read address as the wait expires.
                if (wcnt_q == WAIT_LAST) begin
                    addr_d  = ext(addr_c(5'(idx_q)));
                    state_d = ST_READ_C;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end
            ST_READ_C: begin
                push_valid = !last_q;
                if (!last_q) begin
                    if (push_ready) begin
                        if (idx_q == IDX_C_LAST) begin
                            last_d = 1'b1;
                        end else begin
                            idx_d  = idx_nx;
                            addr_d = ext(addr_c(5'(idx_nx)));
                        end
                    end else begin
                        addr_d = addr_q;
                    end
                end else if (out_valid && out_ready) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            wcnt_q  <= '0;
            clr_q   <= 1'b0;
            last_q  <= 1'b0;
            addr_q  <= '0;
            rw_q    <= 1'b0;
            din_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            wcnt_q  <= wcnt_d;
            clr_q   <= clr_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            rw_q    <= rw_d;
            din_q   <= din_d;
        end
    end

    tpu_out_skid #(
        .W(DATAW)
    ) u_out_skid (
        .clk_i      (clk),
        .rst_i      (rst),
        .s_tvalid_i (push_valid),
        .s_tdata_i  (tpu_dataOut),
        .s_tready_o (push_ready),
        .m_tvalid_o (out_valid),
        .m_tdata_o  (out_data),
        .m_tready_i (out_ready)
    );

endmodule

// File: doc/tpu_host_sequencer.md
Name: tpu_host_sequencer

Overview:
Initiator-side master for the tpuv1 memory-mapped slave port (addr / r_w / dataIn / dataOut). On a start pulse it performs a full matmul job:
- streams A rows, B rows and optional C init words from an input stream into the TPU;
- issues the matmul command and waits for the array to finish;
- reads the C result back onto an output stream with backpressure.

It sits between the host/DMA stream logic and tpuv1.

Parameters:
- DIM, 8: systolic array dimension (rows of A/B/C).
- BITS_C, 16: C element width. Two DATAW words per C row (DIM*BITS_C = 2*DATAW).
- ADDRW, 16: TPU address width.
- DATAW, 64: TPU data width.
- MM_WAIT, 32: idle cycles after the matmul command before C is read.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle job start pulse
- clear_c  in  1  sampled with start; 1 = write zeros to C, no input words consumed
- busy  out  1  job in progress
- done  out  1  one-cycle pulse after last C word accepted downstream
- in_valid  in  1  input word valid
- in_data  in  DATAW  input word (A rows, then B rows, then C words)
- in_ready  out  1  input word accepted when in_valid && in_ready
- out_valid  out  1  result word valid
- out_data  out  DATAW  result word
- out_ready  in  1  downstream accept
- tpu_addr  out  ADDRW  to tpuv1 addr
- tpu_r_w  out  1  to tpuv1 r_w; 1 = write, 0 = read
- tpu_dataIn  out  DATAW  to tpuv1 dataIn
- tpu_dataOut  in  DATAW  from tpuv1 dataOut; combinational read of addressed C half-row

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high.
- Reset values: busy=0, done=0, in_ready=0, out_valid=0, out_data=0, tpu_addr=0, tpu_r_w=0, tpu_dataIn=0. FSM returns to IDLE and index counters clear. Reset mid-job aborts with no further TPU accesses.
- Idle TPU bus: tpu_addr=0 (opcode 0), tpu_r_w=0, tpu_dataIn=0 whenever no access is issued.
- TPU address map, opcode in addr[11:8]:
  - 0x1 write A row r: addr = 0x100 | r<<3
  - 0x2 write B: addr = 0x200, word shifts into memB
  - 0x3 C access: addr = 0x300 | r<<4 | h<<3, h = half (0 = cols 0..3, 1 = cols 4..7)
  - 0x4 matmul: addr = 0x400
- Write timing: one access per cycle. tpu_addr, tpu_r_w and tpu_dataIn are registered outputs presented for exactly one cycle per accepted word.
- FSM states and transitions:
  - IDLE: start -> LOAD_A and latch clear_c. start while busy is ignored.
  - LOAD_A: in_ready=1. Each handshake issues an A write for row idx = 0..DIM-1. After row DIM-1 -> LOAD_B.
  - LOAD_B: same as LOAD_A with opcode 0x2, DIM words in arrival order. After the last word -> LOAD_C.
  - LOAD_C: 2*DIM writes, order r = 0..DIM-1, h = 0 then 1, tpu_r_w=1.
    - clear_c=0: each write consumes an input word.
    - clear_c=1: in_ready=0, tpu_dataIn=0, one write per cycle.
    - After the last write -> MATMUL.
  - MATMUL: one cycle with addr=0x400, tpu_dataIn=0 -> WAIT.
  - WAIT: counter runs MM_WAIT cycles with the bus idle and tpu_dataIn held at 0 -> READ_C.
  - READ_C: drive addr 0x300 | r<<4 | h<<3 with r_w=0, in the same r/h order as LOAD_C.
    - When the output register is free (!out_valid || out_ready), capture tpu_dataOut into out_data, set out_valid and advance the index.
    - Otherwise hold the address.
    - After the last word is accepted downstream -> DONE.
  - DONE: done=1 for one cycle, busy=0 -> IDLE.
- Input gaps: in_ready=0 in every state except LOAD_A, LOAD_B, and LOAD_C with clear_c=0. in_valid gaps stall the FSM; no TPU write is issued in a stalled cycle.
- Output stability: out_valid stays high and out_data stays stable until out_ready.
- Busy: busy=1 from the cycle after start through the DONE cycle exclusive.
- Counter widths: idx counts to 2*DIM-1, width $clog2(2*DIM). The wait counter has width $clog2(MM_WAIT+1). No wrap-around beyond terminal counts.

Decomposition:
- Package tpu_pkg holds:
  - opcode localparams OP_A=4'h1, OP_B=4'h2, OP_C=4'h3, OP_MM=4'h4;
  - the FSM state enum typedef;
  - address-compose helper functions.
- Natural sub-module: tpu_out_skid, a single-entry valid/ready output register.

Test Plan:
- Full job, clear_c=0, A=identity, B rows = 0x0807060504030201, C init 0 -> 16 output words match the B rows split into 16-bit halves; exactly 32 writes then 0x400, and done pulses once.
- clear_c=1 -> in_ready low during LOAD_C; 16 writes at 0x300..0x378 step 8, all dataIn=0, issued in 16 consecutive cycles.
- in_valid toggles every other cycle during LOAD_A -> A writes land on addresses 0x100, 0x108, ..., 0x138 with no duplicates and no writes on gap cycles.
- out_ready held low 10 cycles on the 3rd word -> out_data stable, tpu_addr held at 0x318, no words lost or duplicated.
- rst asserted mid-WAIT -> next cycle all outputs 0 and busy=0; a new start runs a clean job.
- start pulsed while busy -> ignored; total TPU write count remains 33.
